// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_CH resets in order once a
// synchronised lock has been stable for HOLD_CYCLES cycles.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   lock      : qualifying input (async, 2-flop synchronised)
//   soft_rst  : synchronous restart request
//   delay_rst : active-high resets, bit i released i-th
//   seq_done  : high once every channel is released
//   seq_state : 0 WAIT_LOCK, 1 RELEASE, 2 DONE
module reset_sequencer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock,
  input  logic              soft_rst,
  output logic [NUM_CH-1:0] delay_rst,
  output logic              seq_done,
  output logic [1:0]        seq_state
);

  localparam int IDX_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_END =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_END =
    CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_END =
    IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_REL    = 2'd1,
    S_DONE   = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic              r_sync1, r_lock_s;
  logic [CNT_W-1:0]  r_hold, w_hold_nx;
  logic [CNT_W-1:0]  r_stage, w_stage_nx;
  logic [IDX_W-1:0]  r_idx, w_idx_nx;
  logic [NUM_CH-1:0] r_rst, w_rst_nx;
  logic              r_done, w_done_nx;
  logic              w_restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= lock;
      r_lock_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_hold  <= '0;
      r_stage <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      r_stage <= w_stage_nx;
      r_idx   <= w_idx_nx;
      r_rst   <= w_rst_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_stage_nx = r_stage;
    w_idx_nx   = r_idx;
    w_rst_nx   = r_rst;
    w_done_nx  = r_done;
    w_restart  = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        w_rst_nx   = '1;
        w_done_nx  = 1'b0;
        w_stage_nx = '0;
        w_idx_nx   = '0;
        if (soft_rst || !r_lock_s) begin
          w_hold_nx = '0;
        end else if (r_hold == HOLD_END) begin
          w_state_nx = S_REL;
          w_hold_nx  = '0;
        end else begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      S_REL: begin
        if (soft_rst || !r_lock_s) begin
          w_restart = 1'b1;
        end else if (r_stage == STAGE_END) begin
          w_rst_nx   = r_rst &
            ~(NUM_CH'(1) << r_idx);
          w_stage_nx = '0;
          if (r_idx == IDX_END) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end else begin
          w_stage_nx = r_stage + 1'b1;
        end
      end
      S_DONE: begin
        if (soft_rst || !r_lock_s) begin
          w_restart = 1'b1;
        end
      end
      S_UNUSED: begin
        w_restart = 1'b1;
      end
    endcase
    // Restart overrides any release decided above
    if (w_restart) begin
      w_state_nx = S_WAIT;
      w_hold_nx  = '0;
      w_stage_nx = '0;
      w_idx_nx   = '0;
      w_rst_nx   = '1;
      w_done_nx  = 1'b0;
    end
  end

  assign delay_rst = r_rst;
  assign seq_done  = r_done;
  assign seq_state = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer,
// default instance plus a 1-channel, 1/1 cycle instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b1;
  logic       soft_rst = 1'b0;
  logic [3:0] d_rst;
  logic       d_done;
  logic [1:0] d_st;
  logic [0:0] d1_rst;
  logic       d1_done;
  logic [1:0] d1_st;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         t;
    bit         sel;
    logic [3:0] r;
    logic [1:0] st;
    logic       d;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reset_sequencer u_dut (
    .clk       (clk),
    .rst       (rst),
    .lock      (lock),
    .soft_rst  (soft_rst),
    .delay_rst (d_rst),
    .seq_done  (d_done),
    .seq_state (d_st)
  );

  reset_sequencer #(
    .NUM_CH       (1),
    .HOLD_CYCLES  (1),
    .STAGE_CYCLES (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .lock      (lock),
    .soft_rst  (soft_rst),
    .delay_rst (d1_rst),
    .seq_done  (d1_done),
    .seq_state (d1_st)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic push(
    input int t, input bit sel, input logic [3:0] r,
    input logic [1:0] st, input logic d
  );
    exp_t e;
    e.t = t; e.sel = sel; e.r = r; e.st = st; e.d = d;
    sb.push_back(e);
  endtask

  // Expected default trace when edge 1 is b+1
  task automatic push_seq(input int b);
    push(b + 17, 0, 4'hF, 2'd0, 1'b0);
    push(b + 18, 0, 4'hF, 2'd1, 1'b0);
    push(b + 33, 0, 4'hF, 2'd1, 1'b0);
    push(b + 34, 0, 4'hE, 2'd1, 1'b0);
    push(b + 49, 0, 4'hE, 2'd1, 1'b0);
    push(b + 50, 0, 4'hC, 2'd1, 1'b0);
    push(b + 66, 0, 4'h8, 2'd1, 1'b0);
    push(b + 81, 0, 4'h8, 2'd1, 1'b0);
    push(b + 82, 0, 4'h0, 2'd2, 1'b1);
    push(b + 90, 0, 4'h0, 2'd2, 1'b1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      e = sb.pop_front();
      if (e.t < cyc) begin
        chk("missed", cyc, e.t);
      end else if (e.sel) begin
        chk("d1_rst", {3'b0, d1_rst}, e.r);
        chk("d1_st", d1_st, e.st);
        chk("d1_done", d1_done, e.d);
      end else begin
        chk("rst", d_rst, e.r);
        chk("st", d_st, e.st);
        chk("done", d_done, e.d);
      end
    end
  end

  task automatic wait_to(input int t);
    do begin
      @(posedge clk);
      #2;
    end while (cyc < t);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset(output int b);
    rst = 1'b1;
    #1;
    chk("arst_rst", d_rst, 4'hF);
    chk("arst_done", d_done, 1'b0);
    chk("arst_st", d_st, 2'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    b = cyc;
  endtask

  initial begin
    int b;
    @(posedge clk);
    #2;

    // default sequence plus the 1/1/1 instance
    do_reset(b);
    push(b + 2, 1, 4'h1, 2'd0, 1'b0);
    push(b + 3, 1, 4'h1, 2'd1, 1'b0);
    push(b + 4, 1, 4'h0, 2'd2, 1'b1);
    push_seq(b);
    drain();

    // lock loss in DONE, then relock
    b = cyc;
    lock = 1'b0;
    push(b + 2, 0, 4'h0, 2'd2, 1'b1);
    push(b + 3, 0, 4'hF, 2'd0, 1'b0);
    drain();
    wait_to(cyc + 5);
    b = cyc;
    lock = 1'b1;
    push_seq(b);
    drain();

    // one-cycle lock glitch restarts the hold count
    do_reset(b);
    push(b + 18, 0, 4'hF, 2'd0, 1'b0);
    push_seq(b + 10);
    wait_to(b + 9);
    lock = 1'b0;
    wait_to(b + 10);
    lock = 1'b1;
    drain();

    // soft_rst on the bit-2 release edge
    do_reset(b);
    push(b + 50, 0, 4'hC, 2'd1, 1'b0);
    push(b + 65, 0, 4'hC, 2'd1, 1'b0);
    push(b + 66, 0, 4'hF, 2'd0, 1'b0);
    push(b + 81, 0, 4'hF, 2'd0, 1'b0);
    push(b + 82, 0, 4'hF, 2'd1, 1'b0);
    push(b + 98, 0, 4'hE, 2'd1, 1'b0);
    wait_to(b + 65);
    soft_rst = 1'b1;
    wait_to(b + 66);
    soft_rst = 1'b0;
    drain();

    // async rst mid-cycle during RELEASE
    do_reset(b);
    push(b + 34, 0, 4'hE, 2'd1, 1'b0);
    drain();
    wait_to(b + 40);
    chk("pre_arst", d_rst, 4'hE);
    #1;
    do_reset(b);
    push_seq(b);
    drain();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output reset stretcher.
- Releases NUM_CH reset outputs one at a time, in order, with a fixed spacing between them.
- Release starts only after a qualifying input (PLL lock / link-up) has been stable for a programmable hold time.
- Sits between the board-level reset and the clock-domain blocks (Aurora core, FIFOs, user logic). Re-arms on loss of lock or on a soft reset.

Parameters:
NUM_CH, 4, number of sequenced reset outputs (>=1)
CNT_W, 8, width of hold and stage counters; must satisfy 2^CNT_W > max(HOLD_CYCLES, STAGE_CYCLES)
HOLD_CYCLES, 16, consecutive cycles synchronised lock must be high before sequencing starts (>=1)
STAGE_CYCLES, 16, cycles between successive channel releases, and from start of RELEASE to channel 0 release (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
lock  in  1  qualifying input, asynchronous to clk; synchronised internally by 2 flops reset to 0
soft_rst  in  1  synchronous active-high restart request
delay_rst  out  NUM_CH  active-high resets; bit i released i-th
seq_done  out  1  high once all channels are released
seq_state  out  2  FSM state: 0 WAIT_LOCK, 1 RELEASE, 2 DONE, 3 unused

Behaviour:
- Reset and clocking: one clock, clk. rst is asynchronous and active-high.
- rst assertion immediately forces:
  - delay_rst = all ones, seq_done = 0, seq_state = WAIT_LOCK
  - counters = 0, stage index = 0, sync flops = 0
- All outputs are registered.
- lock_s is lock after the 2-flop synchroniser. If lock rises before edge 1, the FSM first samples lock_s = 1 at edge 3.
- WAIT_LOCK:
  - hold_cnt increments on each edge that samples lock_s = 1, and clears on any edge that samples lock_s = 0.
  - On the edge that samples lock_s = 1 for the HOLD_CYCLES-th consecutive time: go to RELEASE, clear stage_cnt, stage index = 0.
- RELEASE:
  - stage_cnt increments every edge.
  - On the STAGE_CYCLES-th edge after entry, or after the previous release, clear delay_rst[idx], increment idx, clear stage_cnt.
  - On the edge that clears delay_rst[NUM_CH-1]: go to DONE and set seq_done = 1 on that same edge.
- DONE: outputs hold (delay_rst = 0, seq_done = 1). This is the only terminal state.
- Restart: in any state, an edge sampling soft_rst = 1 or lock_s = 0 (WAIT_LOCK excluded for lock_s) causes, on that edge:
  - state = WAIT_LOCK, delay_rst = all ones, seq_done = 0, all counters and idx cleared.
  - Restart has priority over any same-edge release or transition.
- soft_rst in WAIT_LOCK clears hold_cnt.
- Released channels are never re-released out of order. Reassertion is always all channels together.
- Loss-of-lock latency:
  - lock falling to delay_rst all ones takes <= 3 edges (2 sync + 1 register).
  - soft_rst to delay_rst all ones takes 1 edge.
- Counters saturate-free: they never exceed their terminal value because they clear on the terminal edge. No wrap-around is reachable with a legal CNT_W.
- Unused state 3 decodes as WAIT_LOCK with the restart actions (all ones, counters cleared).
- Default timing, with lock high before rst deassertion and rst released before edge 1:
  - RELEASE entered at edge 18.
  - delay_rst[0] clears at edge 34, [1] at 50, [2] at 66, [3] at 82.
  - seq_done asserts at edge 82.

Test Plan:
1. Default params, lock=1 constant, rst pulse then released -> delay_rst 4'b1111 until edge 34; 4'b1110 @34, 4'b1100 @50, 4'b1000 @66, 4'b0000 and seq_done=1 @82; seq_state 0→1 @18, 1→2 @82.
2. lock=1, then low for one full cycle around edge 10 (hold_cnt ~7) -> hold count restarts; RELEASE entry delayed to 16 consecutive lock_s-high edges after the glitch clears through the synchroniser; no delay_rst bit changes early.
3. In DONE, drop lock -> delay_rst = 4'b1111, seq_done=0, seq_state=0 within 3 edges. Re-raise lock -> full sequence repeats with the same 16/16 spacing.
4. soft_rst pulse for 1 cycle when delay_rst = 4'b1100 (RELEASE, idx=2), coinciding with a release edge -> restart wins: next value 4'b1111, seq_state=0, and bit 2 is not released.
5. Assert rst asynchronously mid-cycle during RELEASE -> delay_rst goes to all ones and seq_done to 0 before the next clk edge. After release, behaves as scenario 1.
6. NUM_CH=1, HOLD_CYCLES=1, STAGE_CYCLES=1, lock=1 -> RELEASE at edge 3, delay_rst[0]=0 and seq_done=1 at edge 4.
